// File: rtl/grid6_color_scanner.sv
// grid6_color_scanner: steps 2x3-grid colourings into the edge checker.
// Define GRID6_SCAN_FIND_ALL_EN to scan the full space and count hits.
module grid6_color_scanner #(
   parameter int N_VERT     = 6,
   parameter int START_CAND = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [N_VERT-1:0] cand_o,
   input  logic              ok_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              found_o,
   output logic [N_VERT-1:0] sol_o,
   output logic [N_VERT:0]   sol_count_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [N_VERT-1:0] LAST  = '1;
   localparam logic [N_VERT-1:0] FIRST = N_VERT'(START_CAND);

   state_t            state_q, state_d;
   logic [N_VERT-1:0] cand_q, cand_d;
   logic [N_VERT-1:0] sol_q, sol_d;
   logic              found_q, found_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load;
   logic              last_c;
   logic              stop_hit;
   logic              scan_end;

   assign load     = !abort_i && start_i
                     && (state_q != SCAN);
   assign last_c   = (cand_q == LAST);
`ifdef GRID6_SCAN_FIND_ALL_EN
   assign stop_hit = 1'b0;
`else
   assign stop_hit = ok_i;
`endif
   // A hit stops the scan before the terminal test is consulted.
   assign scan_end = stop_hit || last_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cand_q  <= '0;
         sol_q   <= '0;
         found_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         sol_q   <= sol_d;
         found_q <= found_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: if (start_i) state_d = SCAN;
            SCAN: if (scan_end) state_d = DONE;
            DONE: if (start_i) state_d = SCAN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cand_d  = cand_q;
      sol_d   = sol_q;
      found_d = found_q;
      busy_d  = (state_d == SCAN);
      done_d  = (state_d == DONE);
      if (abort_i) begin
         sol_d   = '0;
         found_d = 1'b0;
      end else if (load) begin
         cand_d  = FIRST;
         sol_d   = '0;
         found_d = 1'b0;
      end else if (state_q == SCAN) begin
         if (ok_i && !found_q) begin
            sol_d   = cand_q;
            found_d = 1'b1;
         end
         if (!scan_end) begin
            cand_d = cand_q + N_VERT'(1);
         end
      end
   end

`ifdef GRID6_SCAN_FIND_ALL_EN
   logic [N_VERT:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (abort_i || load) begin
         cnt_d = '0;
      end else if (state_q == SCAN && ok_i) begin
         cnt_d = cnt_q + (N_VERT+1)'(1);
      end
   end

   assign sol_count_o = cnt_q;
`else
   assign sol_count_o = '0;
`endif

   assign cand_o  = cand_q;
   assign sol_o   = sol_q;
   assign found_o = found_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_grid6_color_scanner.sv
// tb_grid6_color_scanner: scoreboard bench with a behavioural
// grid6 checker closing the loop from cand_o back to ok_i.
module tb_grid6_color_scanner;

   localparam int NV = 6;
   localparam int SC = 0;
`ifdef GRID6_SCAN_FIND_ALL_EN
   localparam bit FA = 1'b1;
`else
   localparam bit FA = 1'b0;
`endif

   typedef struct {
      bit         found;
      logic [5:0] sol;
      int         edges;
      logic [6:0] cnt;
      logic [5:0] last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          abort_i = 1'b0;
   logic          tie0 = 1'b0;
   logic          ok_i;
   logic [NV-1:0] cand_o;
   logic [NV-1:0] sol_o;
   logic          busy_o;
   logic          done_o;
   logic          found_o;
   logic [NV:0]   sol_count_o;

   int   errs = 0;
   int   checks = 0;
   exp_t sb[$];
   logic [5:0] cq[$];
   exp_t last_e;

   always #5 clk = ~clk;

   function automatic logic chk(input logic [5:0] x);
      return (x[0] ^ x[1]) & (x[0] ^ x[3])
           & (x[1] ^ x[2]) & (x[1] ^ x[4])
           & (x[2] ^ x[5]) & (x[3] ^ x[4])
           & (x[4] ^ x[5]);
   endfunction

   assign ok_i = tie0 ? 1'b0 : chk(cand_o);

   grid6_color_scanner #(
      .N_VERT(NV),
      .START_CAND(SC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_i(start_i),
      .abort_i(abort_i),
      .cand_o(cand_o),
      .ok_i(ok_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .found_o(found_o),
      .sol_o(sol_o),
      .sol_count_o(sol_count_o)
   );

   task automatic push_exp(input bit tz);
      exp_t e;
      logic [5:0] cv;
      bit hit;
      e.found = 0;
      e.sol = '0;
      e.edges = 0;
      e.cnt = '0;
      e.last = '0;
      cq.delete();
      for (int c = SC; c < 64; c++) begin
         cv = 6'(c);
         e.edges++;
         hit = !tz && chk(cv);
         if (hit) begin
            if (FA) e.cnt = e.cnt + 7'd1;
            if (!e.found) begin
               e.found = 1;
               e.sol = cv;
            end
         end
         if ((hit && !FA) || c == 63) begin
            e.last = cv;
            break;
         end
         cq.push_back(cv + 6'd1);
      end
      sb.push_back(e);
   endtask

   task automatic do_scan(input bit tz, input int poke,
                          input string nm);
      exp_t e;
      logic [5:0] ex;
      int n;
      bit fin;
      @(negedge clk);
      tie0 = tz;
      start_i = 1'b1;
      push_exp(tz);
      @(negedge clk);
      start_i = 1'b0;
      checks++;
      if (cand_o !== 6'(SC) || busy_o !== 1'b1
          || done_o !== 1'b0) begin
         errs++;
         $display("FAIL %s_load cand=%h busy=%b done=%b want %h 1 0",
                  nm, cand_o, busy_o, done_o, 6'(SC));
      end
      fin = 0;
      n = 0;
      while (!fin && n < 200) begin
         start_i = (n + 1 == poke);
         @(negedge clk);
         n++;
         if (done_o === 1'b1) begin
            fin = 1;
         end else begin
            ex = (cq.size() > 0) ? cq.pop_front() : 6'hxx;
            checks++;
            if (cand_o !== ex || busy_o !== 1'b1) begin
               errs++;
               $display("FAIL %s_step%0d cand=%h busy=%b want %h 1",
                        nm, n, cand_o, busy_o, ex);
            end
         end
      end
      start_i = 1'b0;
      e = sb.pop_front();
      last_e = e;
      cq.delete();
      checks++;
      if (!fin || n != e.edges) begin
         errs++;
         $display("FAIL %s_latency done_edge=%0d fin=%0b want %0d",
                  nm, n, fin, e.edges);
      end
      checks++;
      if (found_o !== e.found || sol_o !== e.sol) begin
         errs++;
         $display("FAIL %s_result found=%b sol=%h want %b %h",
                  nm, found_o, sol_o, e.found, e.sol);
      end
      checks++;
      if (sol_count_o !== e.cnt || cand_o !== e.last
          || busy_o !== 1'b0) begin
         errs++;
         $display("FAIL %s_final cnt=%0d cand=%h busy=%b want %0d %h 0",
                  nm, sol_count_o, cand_o, busy_o, e.cnt, e.last);
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (cand_o !== 0 || busy_o !== 0 || done_o !== 0
          || found_o !== 0 || sol_o !== 0
          || sol_count_o !== 0) begin
         errs++;
         $display("FAIL reset_hold c=%h b=%b d=%b f=%b s=%h n=%0d want 0",
                  cand_o, busy_o, done_o, found_o, sol_o, sol_count_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checks++;
         if (cand_o !== 0 || busy_o !== 0 || done_o !== 0
             || found_o !== 0 || sol_o !== 0) begin
            errs++;
            $display("FAIL reset_idle c=%h b=%b d=%b f=%b s=%h want 0",
                     cand_o, busy_o, done_o, found_o, sol_o);
         end
      end
   endtask

   task automatic test_first_hit();
      do_scan(1'b0, 0, "first_hit");
   endtask

   task automatic test_done_hold();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (done_o !== 1'b1 || busy_o !== 1'b0
             || found_o !== last_e.found
             || sol_o !== last_e.sol
             || sol_count_o !== last_e.cnt
             || cand_o !== last_e.last) begin
            errs++;
            $display("FAIL done_hold d=%b b=%b f=%b s=%h c=%h want 1 0 %b %h %h",
                     done_o, busy_o, found_o, sol_o, cand_o,
                     last_e.found, last_e.sol, last_e.last);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_scan(1'b0, 0, "restart");
   endtask

   task automatic test_exhaust();
      do_scan(1'b1, 0, "exhaust");
      test_done_hold();
   endtask

   task automatic test_start_ignored();
      do_scan(1'b0, 5, "start_ign");
   endtask

   task automatic test_abort();
      @(negedge clk);
      tie0 = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (9) @(negedge clk);
      abort_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      start_i = 1'b0;
      checks++;
      if (busy_o !== 0 || done_o !== 0 || found_o !== 0
          || sol_o !== 0 || sol_count_o !== 0) begin
         errs++;
         $display("FAIL abort_scan b=%b d=%b f=%b s=%h n=%0d want 0",
                  busy_o, done_o, found_o, sol_o, sol_count_o);
      end
      @(negedge clk);
      checks++;
      if (busy_o !== 0 || done_o !== 0) begin
         errs++;
         $display("FAIL abort_idle b=%b d=%b want 0 0",
                  busy_o, done_o);
      end
      do_scan(1'b0, 0, "pre_abort");
      @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      checks++;
      if (done_o !== 0 || found_o !== 0 || sol_o !== 0
          || busy_o !== 0 || sol_count_o !== 0) begin
         errs++;
         $display("FAIL abort_done d=%b f=%b s=%h b=%b n=%0d want 0",
                  done_o, found_o, sol_o, busy_o, sol_count_o);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      tie0 = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (12) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (cand_o !== 0 || busy_o !== 0 || done_o !== 0
          || found_o !== 0 || sol_o !== 0
          || sol_count_o !== 0) begin
         errs++;
         $display("FAIL mid_reset c=%h b=%b d=%b f=%b s=%h want 0",
                  cand_o, busy_o, done_o, found_o, sol_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_scan(1'b0, 0, "post_reset");
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_done_hold();
      test_back_to_back();
      test_exhaust();
      test_start_ignored();
      test_abort();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/grid6_color_scanner.md
Name: grid6_color_scanner

Overview:
- Sequential candidate generator that sits directly upstream of the grid6 2-colouring edge checker. That checker is a combinational AND of XORs over the 7 edges of the 2x3 grid: (0,1) (0,3) (1,2) (1,4) (2,5) (3,4) (4,5).
- Drives the checker's x0..x5 inputs with successive 6-bit colourings and consumes its y0 verdict.
- Reports the first valid colouring found, or exhaustion of the candidate space.
- Start/busy/done handshake toward a host controller.

Parameters:
- N_VERT, 6, number of vertices (one colour bit each); candidate width; space is 2^N_VERT.
- START_CAND, 0, first candidate value loaded on start; must be < 2^N_VERT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  level-sampled start request; acted on only in IDLE
- abort_i  in  1  synchronous abort; returns to IDLE from any state
- cand_o  out  N_VERT  candidate colouring to checker; bit i drives x_i
- ok_i  in  1  checker verdict (y0) for the current cand_o, same cycle
- busy_o  out  1  high while in SCAN
- done_o  out  1  high in DONE; held until the next start or abort
- found_o  out  1  valid in DONE; 1 = a valid colouring was found
- sol_o  out  N_VERT  first valid colouring; valid when found_o=1
- sol_count_o  out  N_VERT+1  number of valid colourings (FIND_ALL_EN only; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, cand_o=0, busy_o=0, done_o=0, found_o=0, sol_o=0, sol_count_o=0. Recovery is synchronous to clk.
- States are IDLE, SCAN, DONE. All outputs are registered except cand_o, which is the candidate register itself.
- IDLE:
  - start_i=1 at an edge -> SCAN.
  - Same edge: cand<=START_CAND, found<=0, sol<=0, count<=0, done<=0.
- SCAN, evaluated once per edge:
  - busy_o=1. The checker is combinational, so ok_i is sampled on the same edge that cand_o is presented.
  - ok_i=1 and found=0: sol<=cand, found<=1.
  - Without FIND_ALL_EN, ok_i=1 -> DONE. This takes priority over the terminal check.
  - Else if cand==2^N_VERT-1 -> DONE. No wrap: cand holds at its terminal value.
  - Else cand<=cand+1 (modulo N_VERT bits; only the terminal case could wrap, and it is excluded).
  - START_CAND>0: the scan covers START_CAND..2^N_VERT-1 only.
- DONE:
  - busy_o=0, done_o=1. found_o, sol_o and sol_count_o are held. cand_o holds its last value.
  - start_i=1 restarts directly: DONE->SCAN, same load as from IDLE, done_o falls on that edge.
- start_i while in SCAN is ignored.
- abort_i=1 in any state -> IDLE with done/found/busy cleared; sol_o and count are also cleared. abort_i has priority over start_i and ok_i on the same edge.
- Reset mid-scan: immediate return to reset values; no partial result retained.
- Latency: the start edge loads the candidate. Candidate k (offset from START_CAND) is evaluated at edge k+1 after the start edge. done_o rises on that same edge if it terminates the scan.

Optional Feature:
- Macro: GRID6_SCAN_FIND_ALL_EN.
- Defined:
  - Scan never stops early; always runs to 2^N_VERT-1.
  - Every ok_i=1 increments sol_count_o (saturating is not needed; width covers 2^N_VERT).
  - sol_o keeps the first hit.
- Undefined:
  - Stop at first valid colouring.
  - sol_count_o is driven constant 0.

Test Plan:
1. Reset: hold rst_n=0 mid-clock -> all outputs 0 immediately, state IDLE. Release, idle 5 cycles -> outputs unchanged.
2. Real checker attached, START_CAND=0, pulse start_i -> cand_o steps 0,1,2,...,21. At edge 22 after start: done_o=1, found_o=1, sol_o=6'h15 (x0=1,x1=0,x2=1,x3=0,x4=1,x5=0), busy_o falls.
3. ok_i tied 0 -> 64 evaluation edges, cand_o ends at 6'h3F with no wrap to 0. done_o=1, found_o=0 at edge 64 after start.
4. Assert start_i at scan cycle 5 -> no restart, still finds 6'h15 at edge 22. Then abort_i during a second scan at cycle 10 -> IDLE next edge, done_o=0, found_o=0, sol_o=0.
5. Drop rst_n at scan cycle 12 -> all outputs 0 asynchronously. New start after release -> fresh scan from 0, same result as scenario 2.
6. GRID6_SCAN_FIND_ALL_EN defined, real checker -> scan runs full 64 candidates. Result: done_o at edge 64, found_o=1, sol_o=6'h15, sol_count_o=2 (hits at 6'h15 and 6'h2A).
